ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 175 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ============================================================================
//  Module   : ifetch_unit
//  Brief    : Single-outstanding instruction fetch FSM (IDLE/REQ/UPDATE) that
//             drives the instruction memory, latches IR and updates the PC.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_unit #(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] npc,
    output logic        pc_wr,
    output logic        fetch_busy,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam logic [9:0] c_TIMEOUT = 10'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t      r_state, w_state;
    logic [9:0]  r_cnt, w_cnt;
    logic        r_rec, w_rec;
    logic [31:0] r_rec_pc, w_rec_pc;
    logic        r_imem_req, w_imem_req;
    logic [31:0] r_imem_addr, w_imem_addr;
    logic [31:0] r_ir, w_ir;
    logic        r_ir_valid, w_ir_valid;
    logic [31:0] r_npc, w_npc;
    logic        r_pc_wr, w_pc_wr;
    logic        r_mis, w_mis;
    logic        r_to, w_to;

    // Redirect seen on this very edge counts as recorded (latest wins).
    logic        w_redir_any;
    logic [31:0] w_redir_tgt;
    logic [9:0]  w_cnt_inc;

    assign w_redir_any = redirect_valid | r_rec;
    assign w_redir_tgt = redirect_valid ? redirect_pc : r_rec_pc;
    assign w_cnt_inc   = r_cnt + 10'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rec       <= 1'b0;
            r_rec_pc    <= '0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_npc       <= '0;
            r_pc_wr     <= 1'b0;
            r_mis       <= 1'b0;
            r_to        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_rec       <= w_rec;
            r_rec_pc    <= w_rec_pc;
            r_imem_req  <= w_imem_req;
            r_imem_addr <= w_imem_addr;
            r_ir        <= w_ir;
            r_ir_valid  <= w_ir_valid;
            r_npc       <= w_npc;
            r_pc_wr     <= w_pc_wr;
            r_mis       <= w_mis;
            r_to        <= w_to;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_rec       = r_rec;
        w_rec_pc    = r_rec_pc;
        w_imem_req  = 1'b0;
        w_imem_addr = r_imem_addr;
        w_ir        = r_ir;
        w_ir_valid  = r_ir_valid;
        w_npc       = r_npc;
        w_pc_wr     = 1'b0;
        w_mis       = 1'b0;
        w_to        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_state    = S_UPDATE;
                    w_npc      = redirect_pc;
                    w_pc_wr    = 1'b1;
                    w_ir_valid = 1'b0;
                end else if (fetch_start) begin
                    if (pc[1:0] == 2'b00) begin
                        w_state     = S_REQ;
                        w_imem_addr = pc;
                        w_imem_req  = 1'b1;
                        w_ir_valid  = 1'b0;
                        w_rec       = 1'b0;
                        w_cnt       = '0;
                    end else begin
                        w_mis = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_imem_req = 1'b1;
                if (redirect_valid) begin
                    w_rec    = 1'b1;
                    w_rec_pc = redirect_pc;
                end
                // Ready is checked first so it beats a coincident timeout.
                if (imem_ready) begin
                    w_state    = S_UPDATE;
                    w_imem_req = 1'b0;
                    w_pc_wr    = 1'b1;
                    if (w_redir_any) begin
                        w_npc = w_redir_tgt;
                    end else begin
                        w_npc      = pc + PC_STEP;
                        w_ir       = imem_rdata;
                        w_ir_valid = 1'b1;
                    end
                end else if (w_cnt_inc == c_TIMEOUT) begin
                    w_state    = S_IDLE;
                    w_imem_req = 1'b0;
                    w_to       = 1'b1;
                    w_rec      = 1'b0;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            S_UPDATE: begin
                w_state = S_IDLE;
                w_rec   = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_imem_addr;
    assign ir           = r_ir;
    assign ir_valid     = r_ir_valid;
    assign npc          = r_npc;
    assign pc_wr        = r_pc_wr;
    assign misalign_err = r_mis;
    assign timeout_err  = r_to;
    assign fetch_busy   = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
//  Module   : tb_ifetch_unit
//  Brief    : Directed scoreboard bench for ifetch_unit (TIMEOUT=8).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

    localparam int c_K_PCWR = 0;
    localparam int c_K_MIS  = 1;
    localparam int c_K_TO   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        fetch_start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] npc;
    logic        pc_wr;
    logic        fetch_busy;
    logic        misalign_err;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          kind;
        logic [31:0] npc;
        logic [31:0] ir;
        logic        irv;
    } exp_t;

    exp_t sb[$];

    ifetch_unit #(.TIMEOUT(8), .PC_STEP(32'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .fetch_start    (fetch_start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .ir             (ir),
        .ir_valid       (ir_valid),
        .npc            (npc),
        .pc_wr          (pc_wr),
        .fetch_busy     (fetch_busy),
        .misalign_err   (misalign_err),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] n, input logic [31:0] i, input logic v);
        exp_t e;
        e.kind = kind; e.npc = n; e.ir = i; e.irv = v;
        sb.push_back(e);
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (!rst && (pc_wr || misalign_err || timeout_err)) begin
                k = pc_wr ? c_K_PCWR : (misalign_err ? c_K_MIS : c_K_TO);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got kind %0d expected none (npc=0x%08h)", k, npc);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 32'(k), 32'(e.kind));
                    if (e.kind == c_K_PCWR) chk("npc", npc, e.npc);
                    chk("ir", ir, e.ir);
                    chk("ir_valid", 32'(ir_valid), 32'(e.irv));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fork
            monitor();
        join_none

        // Reset state
        cyc(2);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_ir", ir, 0);
        chk("rst_npc", npc, 0);
        chk("rst_busy", 32'(fetch_busy), 0);
        rst = 1'b0;
        cyc(1);

        // Normal fetch, ready after 3 cycles
        pc = 32'h0000_0100;
        fetch_start = 1'b1;
        push(c_K_PCWR, 32'h0000_0104, 32'h8C01_0004, 1'b1);
        cyc(1);
        fetch_start = 1'b0;
        chk("f1_req", 32'(imem_req), 1);
        chk("f1_addr", imem_addr, 32'h0000_0100);
        chk("f1_busy", 32'(fetch_busy), 1);
        cyc(2);
        imem_ready = 1'b1; imem_rdata = 32'h8C01_0004;
        cyc(1);
        imem_ready = 1'b0; imem_rdata = '0;
        chk("f1_pcwr", 32'(pc_wr), 1);
        chk("f1_req_low", 32'(imem_req), 0);
        cyc(1);
        chk("f1_pcwr_low", 32'(pc_wr), 0);
        chk("f1_idle", 32'(fetch_busy), 0);
        pc = 32'h0000_0104;

        // Redirect during REQ discards the fetched word
        pc = 32'h0000_0100;
        fetch_start = 1'b1;
        push(c_K_PCWR, 32'h0000_0400, 32'h8C01_0004, 1'b0);
        cyc(1);
        fetch_start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        cyc(1);
        redirect_valid = 1'b0; redirect_pc = '0;
        cyc(1);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc(1);
        imem_ready = 1'b0;
        cyc(1);
        pc = 32'h0000_0400;

        // Misaligned PC
        pc = 32'h0000_0102;
        fetch_start = 1'b1;
        push(c_K_MIS, 32'h0, 32'h8C01_0004, 1'b0);
        cyc(1);
        fetch_start = 1'b0;
        chk("mis_pulse", 32'(misalign_err), 1);
        chk("mis_no_req", 32'(imem_req), 0);
        chk("mis_idle", 32'(fetch_busy), 0);
        cyc(1);
        chk("mis_pulse_end", 32'(misalign_err), 0);
        chk("mis_no_req2", 32'(imem_req), 0);

        // Timeout: imem_req held exactly TIMEOUT cycles
        pc = 32'h0000_0400;
        fetch_start = 1'b1;
        push(c_K_TO, 32'h0, 32'h8C01_0004, 1'b0);
        cyc(1);
        fetch_start = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req) n++;
            if (timeout_err) break;
        end
        chk("to_req_cycles", 32'(n), 8);
        chk("to_seen", 32'(timeout_err), 1);
        cyc(1);
        chk("to_idle", 32'(fetch_busy), 0);
        chk("to_pulse_end", 32'(timeout_err), 0);

        // Redirect in IDLE beats fetch_start
        fetch_start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0800;
        push(c_K_PCWR, 32'h0000_0800, 32'h8C01_0004, 1'b0);
        cyc(1);
        fetch_start = 1'b0; redirect_valid = 1'b0;
        chk("idle_redir_noreq", 32'(imem_req), 0);
        cyc(1);
        pc = 32'h0000_0800;

        // Wrap at top of address space, then back-to-back fetch at T+k+2
        pc = 32'hFFFF_FFFC;
        fetch_start = 1'b1;
        push(c_K_PCWR, 32'h0000_0000, 32'h1234_5678, 1'b1);
        cyc(1);
        fetch_start = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        cyc(1);
        imem_ready = 1'b0;
        cyc(1);
        pc = 32'h0000_0000;
        fetch_start = 1'b1;
        push(c_K_PCWR, 32'h0000_0004, 32'hAABB_CCDD, 1'b1);
        cyc(1);
        fetch_start = 1'b0;
        chk("b2b_req", 32'(imem_req), 1);
        chk("b2b_addr", imem_addr, 32'h0000_0000);
        imem_ready = 1'b1; imem_rdata = 32'hAABB_CCDD;
        cyc(1);
        imem_ready = 1'b0;
        cyc(1);
        pc = 32'h0000_0004;

        // Ready on the same edge as the timeout: ready wins
        pc = 32'h0000_0010;
        fetch_start = 1'b1;
        push(c_K_PCWR, 32'h0000_0014, 32'h0BAD_F00D, 1'b1);
        cyc(1);
        fetch_start = 1'b0;
        cyc(7);
        imem_ready = 1'b1; imem_rdata = 32'h0BAD_F00D;
        cyc(1);
        imem_ready = 1'b0;
        cyc(1);
        pc = 32'h0000_0014;

        // Asynchronous reset mid-REQ; late ready ignored
        pc = 32'h0000_0020;
        fetch_start = 1'b1;
        cyc(1);
        fetch_start = 1'b0;
        cyc(1);
        chk("mid_req", 32'(imem_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 32'(imem_req), 0);
        chk("arst_ir", ir, 0);
        chk("arst_irv", 32'(ir_valid), 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_busy", 32'(fetch_busy), 0);
        cyc(1);
        rst = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'h5555_5555;
        cyc(1);
        imem_ready = 1'b0;
        cyc(2);
        chk("late_ready_ir", ir, 0);
        chk("late_ready_pcwr", 32'(pc_wr), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
